// File: rtl/tcdm_master_shim.sv
// tcdm_master_shim: master-side adapter between a core/DMA port and one
// master port of the TCDM interconnect. Requests queue in a small FIFO and are
// issued only when a response slot is guaranteed, so network responses (which
// arrive exactly one cycle after grant) are never dropped.
// Optional build macro: TCDM_SHIM_FALLTHROUGH_EN -- an incoming request can
// bypass the empty request FIFO and reach the network in the same cycle.
module tcdm_master_shim #(
  parameter int unsigned AddWidth      = 5,
  parameter int unsigned ReqDataWidth  = 32,
  parameter int unsigned RespDataWidth = 32,
  parameter int unsigned ReqDepth      = 2,
  parameter int unsigned RespDepth     = 2
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     in_valid_i,
  output logic                     in_ready_o,
  input  logic [AddWidth-1:0]      in_add_i,
  input  logic [ReqDataWidth-1:0]  in_data_i,
  output logic                     req_o,
  input  logic                     gnt_i,
  output logic [AddWidth-1:0]      add_o,
  output logic [ReqDataWidth-1:0]  data_o,
  input  logic [RespDataWidth-1:0] rdata_i,
  input  logic                     rvld_i,
  output logic                     resp_valid_o,
  input  logic                     resp_ready_i,
  output logic [RespDataWidth-1:0] resp_rdata_o,
  output logic                     err_o
);

  localparam int unsigned QPW = (ReqDepth > 1) ? $clog2(ReqDepth) : 1;
  localparam int unsigned QCW = $clog2(ReqDepth + 1);
  localparam int unsigned SPW = $clog2(RespDepth);
  localparam int unsigned SCW = $clog2(RespDepth + 1);

  // request FIFO
  logic [ReqDepth-1:0][AddWidth-1:0]     qadd_q;
  logic [ReqDepth-1:0][ReqDataWidth-1:0] qdat_q;
  logic [QPW-1:0] qwr_q, qrd_q;
  logic [QCW-1:0] qcnt_q, qcnt_d;
  // response FIFO
  logic [RespDepth-1:0][RespDataWidth-1:0] sdat_q;
  logic [SPW-1:0] swr_q, srd_q;
  logic [SCW-1:0] scnt_q, scnt_d;

  logic inflight_q, err_q;
  logic q_nonempty, credit_ok, grant, q_push, q_pop, s_push, s_pop;

  function automatic logic [QPW-1:0] qinc(input logic [QPW-1:0] p);
    return (p == QPW'(ReqDepth - 1)) ? '0 : p + 1'b1;
  endfunction

  function automatic logic [SPW-1:0] sinc(input logic [SPW-1:0] p);
    return (p == SPW'(RespDepth - 1)) ? '0 : p + 1'b1;
  endfunction

  // A request may only go out if the response FIFO can hold every answer
  // already owed plus this one; inflight covers the response still on the wire.
  assign credit_ok  = (int'(scnt_q) + int'(inflight_q)) < int'(RespDepth);
  assign q_nonempty = (qcnt_q != '0);
  assign in_ready_o = int'(qcnt_q) < int'(ReqDepth);

`ifdef TCDM_SHIM_FALLTHROUGH_EN
  logic ft;
  // Bypass only when nothing older is queued, so issue order is preserved.
  assign ft     = in_valid_i & ~q_nonempty & credit_ok;
  assign req_o  = (q_nonempty & credit_ok) | ft;
  assign add_o  = q_nonempty ? qadd_q[qrd_q] : in_add_i;
  assign data_o = q_nonempty ? qdat_q[qrd_q] : in_data_i;
  assign grant  = req_o & gnt_i;
  assign q_push = in_valid_i & in_ready_o & ~(ft & gnt_i);
  assign q_pop  = grant & q_nonempty;
`else
  assign req_o  = q_nonempty & credit_ok;
  assign add_o  = qadd_q[qrd_q];
  assign data_o = qdat_q[qrd_q];
  assign grant  = req_o & gnt_i;
  assign q_push = in_valid_i & in_ready_o;
  assign q_pop  = grant;
`endif

  assign s_push       = rvld_i & inflight_q;
  assign resp_valid_o = (scnt_q != '0);
  assign s_pop        = resp_valid_o & resp_ready_i;
  assign resp_rdata_o = sdat_q[srd_q];
  assign err_o        = err_q;

  // Occupancy next-state for both FIFOs.
  always_comb begin
    qcnt_d = qcnt_q;
    scnt_d = scnt_q;
    case ({q_push, q_pop})
      2'b10:   qcnt_d = qcnt_q + QCW'(1);
      2'b01:   qcnt_d = qcnt_q - QCW'(1);
      default: qcnt_d = qcnt_q;
    endcase
    case ({s_push, s_pop})
      2'b10:   scnt_d = scnt_q + SCW'(1);
      2'b01:   scnt_d = scnt_q - SCW'(1);
      default: scnt_d = scnt_q;
    endcase
  end

  // FIFO storage, pointers, inflight tracking and sticky protocol error.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      qadd_q     <= '0;
      qdat_q     <= '0;
      qwr_q      <= '0;
      qrd_q      <= '0;
      qcnt_q     <= '0;
      sdat_q     <= '0;
      swr_q      <= '0;
      srd_q      <= '0;
      scnt_q     <= '0;
      inflight_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      if (q_push) begin
        qadd_q[qwr_q] <= in_add_i;
        qdat_q[qwr_q] <= in_data_i;
        qwr_q         <= qinc(qwr_q);
      end
      if (q_pop) qrd_q <= qinc(qrd_q);
      qcnt_q <= qcnt_d;
      if (s_push) begin
        sdat_q[swr_q] <= rdata_i;
        swr_q         <= sinc(swr_q);
      end
      if (s_pop) srd_q <= sinc(srd_q);
      scnt_q     <= scnt_d;
      inflight_q <= grant;
      // A stray response or a missing one both break the one-cycle contract.
      if (rvld_i != inflight_q) err_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_tcdm_master_shim.sv
// tb_tcdm_master_shim: directed bench for tcdm_master_shim with default sizes
// (ReqDepth=2, RespDepth=2). A tiny network model answers each grant one cycle
// later with data derived from the granted address.
module tb_tcdm_master_shim;
  localparam int AW = 5;
  localparam int DW = 32;

  logic          clk_i = 1'b0;
  logic          rst_ni;
  logic          in_valid_i, in_ready_o;
  logic [AW-1:0] in_add_i;
  logic [DW-1:0] in_data_i;
  logic          req_o, gnt_i;
  logic [AW-1:0] add_o;
  logic [DW-1:0] data_o, rdata_i, resp_rdata_o;
  logic          rvld_i, resp_valid_o, resp_ready_i, err_o;

  tcdm_master_shim dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .in_add_i(in_add_i), .in_data_i(in_data_i),
    .req_o(req_o), .gnt_i(gnt_i), .add_o(add_o), .data_o(data_o),
    .rdata_i(rdata_i), .rvld_i(rvld_i),
    .resp_valid_o(resp_valid_o), .resp_ready_i(resp_ready_i),
    .resp_rdata_o(resp_rdata_o), .err_o(err_o)
  );

  always #5 clk_i = ~clk_i;

  int n_vec = 0;
  int n_err = 0;
  logic [AW-1:0] gq[$];
  logic [DW-1:0] rq[$];
  bit acc;
  bit net_drop = 1'b0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] net_data(input logic [AW-1:0] a);
    return (a == 5'd5) ? 32'hDEAD : 32'h11 * a;
  endfunction

  // One clock: sample handshakes before the edge, update inputs after it.
  task automatic tick();
    bit g;
    bit r;
    logic [AW-1:0] ga;
    g  = req_o & gnt_i;
    ga = add_o;
    acc = in_valid_i & in_ready_o;
    r  = resp_valid_o & resp_ready_i;
    if (r) rq.push_back(resp_rdata_o);
    if (g) gq.push_back(ga);
    @(posedge clk_i); #1;
    if (acc) in_valid_i = 1'b0;
    rvld_i  = g & ~net_drop;
    rdata_i = g ? net_data(ga) : '0;
  endtask

  task automatic push(input logic [AW-1:0] a, input logic [DW-1:0] d);
    in_valid_i = 1'b1; in_add_i = a; in_data_i = d;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (acc) return;
    end
    chk("push_acc", {31'd0, acc}, 32'd1);
    in_valid_i = 1'b0;
  endtask

  task automatic do_reset();
    rst_ni = 1'b0;
    tick(); tick();
    rst_ni = 1'b1;
  endtask

  initial begin
    rst_ni = 1'b0; in_valid_i = 1'b0; in_add_i = '0; in_data_i = '0;
    gnt_i = 1'b0; rdata_i = '0; rvld_i = 1'b0; resp_ready_i = 1'b0;

    // reset state
    do_reset();
    chk("rst_req", {31'd0, req_o}, 32'd0);
    chk("rst_rvalid", {31'd0, resp_valid_o}, 32'd0);
    chk("rst_err", {31'd0, err_o}, 32'd0);
    chk("rst_add", {27'd0, add_o}, 32'd0);
    chk("rst_data", data_o, 32'd0);
    chk("rst_rdata", resp_rdata_o, 32'd0);
    chk("rst_ready", {31'd0, in_ready_o}, 32'd1);

    // single read, grant tied high
    gnt_i = 1'b1; in_valid_i = 1'b1; in_add_i = 5'd5; in_data_i = 32'hA5;
`ifdef TCDM_SHIM_FALLTHROUGH_EN
    chk("ft_req_N", {31'd0, req_o}, 32'd1);
    chk("ft_add_N", {27'd0, add_o}, 32'd5);
    chk("ft_data_N", data_o, 32'hA5);
    tick();
    chk("ft_rvalid_N1", {31'd0, resp_valid_o}, 32'd0);
    tick();
    chk("ft_rvalid_N2", {31'd0, resp_valid_o}, 32'd1);
    chk("ft_rdata_N2", resp_rdata_o, 32'hDEAD);
`else
    chk("sr_req_N", {31'd0, req_o}, 32'd0);
    tick();
    chk("sr_req_N1", {31'd0, req_o}, 32'd1);
    chk("sr_add_N1", {27'd0, add_o}, 32'd5);
    chk("sr_data_N1", data_o, 32'hA5);
    tick();
    chk("sr_req_N2", {31'd0, req_o}, 32'd0);
    chk("sr_rvalid_N2", {31'd0, resp_valid_o}, 32'd0);
    tick();
    chk("sr_rvalid_N3", {31'd0, resp_valid_o}, 32'd1);
    chk("sr_rdata_N3", resp_rdata_o, 32'hDEAD);
`endif
    chk("sr_err", {31'd0, err_o}, 32'd0);
    resp_ready_i = 1'b1;
    tick();
    resp_ready_i = 1'b0;
    chk("sr_drained", {31'd0, resp_valid_o}, 32'd0);

    // grant stall and full request FIFO
    gq.delete(); rq.delete();
    gnt_i = 1'b0; resp_ready_i = 1'b1;
    push(5'd1, 32'h101);
    push(5'd2, 32'h102);
    in_valid_i = 1'b1; in_add_i = 5'd3; in_data_i = 32'h103;
    chk("full_ready", {31'd0, in_ready_o}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      chk("stall_req", {31'd0, req_o}, 32'd1);
      chk("stall_add", {27'd0, add_o}, 32'd1);
      chk("stall_data", data_o, 32'h101);
      tick();
    end
    gnt_i = 1'b1;
    for (int i = 0; i < 20; i++) tick();
    chk("stall_ngnt", gq.size(), 32'd3);
    for (int i = 0; i < 3; i++) begin
      chk("stall_gorder", {27'd0, gq[i]}, 32'(i + 1));
    end
    chk("stall_nresp", rq.size(), 32'd3);
    chk("stall_r0", rq[0], 32'h11);
    chk("stall_r1", rq[1], 32'h22);
    chk("stall_r2", rq[2], 32'h33);

    // credit backpressure: responses held, only RespDepth grants go out
    gq.delete(); rq.delete();
    resp_ready_i = 1'b0; gnt_i = 1'b1;
    for (int i = 1; i <= 4; i++) push(AW'(i), 32'(i));
    for (int i = 0; i < 4; i++) tick();
    chk("cr_ngnt", gq.size(), 32'd2);
    chk("cr_req", {31'd0, req_o}, 32'd0);
    chk("cr_rvalid", {31'd0, resp_valid_o}, 32'd1);
    chk("cr_head", resp_rdata_o, 32'h11);
    chk("cr_ready", {31'd0, in_ready_o}, 32'd0);
    resp_ready_i = 1'b1;
    for (int i = 0; i < 20; i++) tick();
    chk("cr_ngnt_all", gq.size(), 32'd4);
    chk("cr_nresp", rq.size(), 32'd4);
    for (int i = 0; i < 4; i++) begin
      chk("cr_rorder", rq[i], 32'h11 * (i + 1));
    end
    chk("cr_empty", {31'd0, resp_valid_o}, 32'd0);
    chk("cr_err", {31'd0, err_o}, 32'd0);

    // stray response sets sticky error, nothing pushed
    rvld_i = 1'b1; rdata_i = 32'hBAD;
    chk("pe_pre", {31'd0, err_o}, 32'd0);
    tick();
    chk("pe_err", {31'd0, err_o}, 32'd1);
    chk("pe_nopush", {31'd0, resp_valid_o}, 32'd0);
    tick(); tick();
    chk("pe_sticky", {31'd0, err_o}, 32'd1);
    do_reset();
    chk("pe_rst", {31'd0, err_o}, 32'd0);

    // missing response after a grant also flags
    net_drop = 1'b1;
    push(5'd7, 32'h7);
    tick(); tick();
    chk("miss_err", {31'd0, err_o}, 32'd1);
    chk("miss_rvalid", {31'd0, resp_valid_o}, 32'd0);
    net_drop = 1'b0;
    do_reset();
    chk("miss_rst", {31'd0, err_o}, 32'd0);
    chk("miss_req", {31'd0, req_o}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
